icache_resp: RTL and testbench

- Instruction-side responder for the fetch-stage requester: accepts fetch addresses on the inst_sram interface and returns instruction words.
- Drives the icache_ask / icache_stall pair that the fetch stage consumes.
- Direct-mapped, read-only cache with line refill from a burst memory port.
- Uncached single-word path for kseg1 (boot ROM at 0xBFC00000).

---
 rtl/icache_resp_pkg.sv | 27 ++
 rtl/icache_resp_if.sv | 30 +++
 rtl/icache_resp_data_ram.sv | 29 ++
 rtl/icache_resp.sv | 118 +++++++++++
 tb/tb_icache_resp.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_resp_pkg.sv
// rtl/icache_resp_pkg.sv - shared state encoding, segment constant and width helpers
package icache_resp_pkg;

    typedef enum logic [2:0] {
        LOOKUP,
        MISS_REQ,
        REFILL,
        UC_REQ,
        UC_WAIT,
        RESP
    } state_t;

    localparam logic [2:0] KSEG1 = 3'b101;

    localparam int INDEX_W_DEF    = 7;
    localparam int LINE_WORDS_DEF = 4;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Tag covers every physical bit above index and offset, including the zeroed top bits.
    function automatic int tag_w(input int index_w, input int line_words);
        return 32 - index_w - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_resp_if.sv
// rtl/icache_resp_if.sv - fetch-side and memory-side signal bundle for icache_resp
interface icache_resp_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic        cache_inv_i;
    logic        icache_ask;
    logic        icache_stall;
    logic [31:0] inst_rdata;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_last;

    modport slave (
        input  inst_sram_en, inst_sram_addr, cache_inv_i,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
        output icache_ask, icache_stall, inst_rdata,
        output mem_rd_req, mem_rd_addr, mem_rd_len
    );

    modport master (
        output inst_sram_en, inst_sram_addr, cache_inv_i,
        output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
        input  icache_ask, icache_stall, inst_rdata,
        input  mem_rd_req, mem_rd_addr, mem_rd_len
    );
endinterface

// File: rtl/icache_resp_data_ram.sv
// rtl/icache_resp_data_ram.sv - line data array, synchronous read, one word write per cycle
module icache_data_ram #(
    parameter int INDEX_W    = 7,
    parameter int LINE_WORDS = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rd_en,
    input  logic [INDEX_W+$clog2(LINE_WORDS)-1:0] i_rd_addr,
    output logic [31:0]                           o_rd_data,
    input  logic                                  i_wr_en,
    input  logic [INDEX_W+$clog2(LINE_WORDS)-1:0] i_wr_addr,
    input  logic [31:0]                           i_wr_data
);
    localparam int AW = INDEX_W + $clog2(LINE_WORDS);

    logic [31:0] r_mem [1<<AW];
    logic [31:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/icache_resp.sv
// rtl/icache_resp.sv - direct-mapped read-only instruction cache responder with kseg1 bypass
module icache_resp
    import icache_resp_pkg::*;
#(
    parameter int          INDEX_W    = INDEX_W_DEF,
    parameter int          LINE_WORDS = LINE_WORDS_DEF,
    parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    icache_resp_if.slave  bus
);
    localparam int          OFFSET_W  = offset_w(LINE_WORDS);
    localparam int          TAG_W     = tag_w(INDEX_W, LINE_WORDS);
    localparam int          LINES     = 1 << INDEX_W;
    localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS*4 - 1);

    state_t              r_state, w_next;
    logic [31:0]         r_addr, r_rdata, r_cap;
    logic                r_pend, r_inv_pend;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag [LINES];
    logic [OFFSET_W-1:0] r_beat;

    logic [31:0]         w_phys, w_ram_rdata;
    logic [INDEX_W-1:0]  w_req_idx;
    logic [OFFSET_W-1:0] w_req_off;
    logic [TAG_W-1:0]    w_req_tag;
    logic                w_uc, w_hit, w_stall, w_ask, w_beat_wr, w_fill_done;

    assign w_phys    = {3'b000, r_addr[28:0]};
    assign w_req_idx = r_addr[OFFSET_W+2 +: INDEX_W];
    assign w_req_off = r_addr[2 +: OFFSET_W];
    assign w_req_tag = w_phys[31 -: TAG_W];
    assign w_uc      = (r_addr[31:29] == KSEG1);

    assign w_hit = (r_state == LOOKUP) && r_pend && !w_uc && r_valid[w_req_idx]
                   && (r_tag[w_req_idx] == w_req_tag);

    assign w_stall = ((r_state == LOOKUP) && r_pend && !w_hit)
                   || (r_state == MISS_REQ) || (r_state == REFILL)
                   || (r_state == UC_REQ)   || (r_state == UC_WAIT);

    assign w_ask       = bus.inst_sram_en && (r_state == LOOKUP) && !w_stall;
    assign w_beat_wr   = (r_state == REFILL) && bus.mem_rd_valid;
    assign w_fill_done = w_beat_wr && bus.mem_rd_last;

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOOKUP:   if (r_pend && !w_hit) w_next = w_uc ? UC_REQ : MISS_REQ;
            MISS_REQ: if (bus.mem_rd_ready) w_next = REFILL;
            REFILL:   if (w_fill_done) w_next = RESP;
            UC_REQ:   if (bus.mem_rd_ready) w_next = UC_WAIT;
            UC_WAIT:  if (bus.mem_rd_valid) w_next = RESP;
            RESP:     w_next = LOOKUP;
            default:  w_next = LOOKUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOOKUP;
            r_pend     <= 1'b0;
            r_addr     <= '0;
            r_rdata    <= RESET_INST;
            r_cap      <= '0;
            r_beat     <= '0;
            r_valid    <= '0;
            r_inv_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_ask;
            if (w_ask) r_addr <= bus.inst_sram_addr;

            if (w_hit) r_rdata <= w_ram_rdata;
            else if (r_state == RESP) r_rdata <= r_cap;

            if (w_beat_wr && (r_beat == w_req_off)) r_cap <= bus.mem_rd_data;
            else if ((r_state == UC_WAIT) && bus.mem_rd_valid) r_cap <= bus.mem_rd_data;

            if (r_state == MISS_REQ) r_beat <= '0;
            else if (w_beat_wr) r_beat <= r_beat + OFFSET_W'(1);

            // An invalidate seen mid-miss is deferred so it also wipes the line just filled.
            if ((r_state == LOOKUP) && bus.cache_inv_i) r_valid <= '0;
            else if ((r_state == RESP) && (r_inv_pend || bus.cache_inv_i)) r_valid <= '0;
            else if (w_fill_done) r_valid[w_req_idx] <= 1'b1;

            if (r_state == RESP) r_inv_pend <= 1'b0;
            else if ((r_state != LOOKUP) && bus.cache_inv_i) r_inv_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_done) r_tag[w_req_idx] <= w_req_tag;
    end

    icache_data_ram #(
        .INDEX_W    (INDEX_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_data_ram (
        .i_clk     (clk),
        .i_rd_en   (w_ask),
        .i_rd_addr (bus.inst_sram_addr[2 +: INDEX_W+OFFSET_W]),
        .o_rd_data (w_ram_rdata),
        .i_wr_en   (w_beat_wr),
        .i_wr_addr ({w_req_idx, r_beat}),
        .i_wr_data (bus.mem_rd_data)
    );

    assign bus.icache_ask   = w_ask;
    assign bus.icache_stall = w_stall;
    assign bus.inst_rdata   = w_hit ? w_ram_rdata : ((r_state == RESP) ? r_cap : r_rdata);
    assign bus.mem_rd_req   = (r_state == MISS_REQ) || (r_state == UC_REQ);
    assign bus.mem_rd_addr  = (r_state == UC_REQ) ? (w_phys & ~32'h3) : (w_phys & LINE_MASK);
    assign bus.mem_rd_len   = (r_state == UC_REQ) ? 8'd0 : 8'(LINE_WORDS - 1);
endmodule

// File: tb/tb_icache_resp.sv
// tb/tb_icache_resp.sv - scoreboard bench for icache_resp with a burst memory responder
module tb_icache_resp;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_resp_if bus();

    icache_resp #(
        .INDEX_W    (7),
        .LINE_WORDS (4),
        .RESET_INST (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [39:0] exp_mem_q[$];
    int          n_mem_req   = 0;
    int          beat_cnt    = 0;
    int          ready_delay = 1;
    bit          inv_on_beat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: mem_word = 32'h0000_0011;
            32'h0000_1004: mem_word = 32'h0000_0022;
            32'h0000_1008: mem_word = 32'h0000_0033;
            32'h0000_100C: mem_word = 32'h0000_0044;
            32'h0000_3000: mem_word = 32'h0000_00A0;
            32'h1FC0_0000: mem_word = 32'h3C08_BFC0;
            default:       mem_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Memory responder: checks each request against the expected queue, then returns beats.
    initial begin : responder
        logic [31:0] a;
        logic [7:0]  l;
        logic [39:0] e;
        bus.cache_inv_i  = 1'b0;
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        bus.mem_rd_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.mem_rd_req === 1'b1) begin
                a = bus.mem_rd_addr;
                l = bus.mem_rd_len;
                n_mem_req++;
                beat_cnt = 0;
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual=%h required=none", a);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_rd_addr", a, e[39:8]);
                    check("mem_rd_len", {24'h0, l}, {24'h0, e[7:0]});
                end
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    check("mem_addr_stable", bus.mem_rd_addr, a);
                    check("mem_req_held", {31'h0, bus.mem_rd_req}, 32'h1);
                end
                bus.mem_rd_ready = 1'b1;
                @(negedge clk);
                bus.mem_rd_ready = 1'b0;
                for (int b = 0; b <= int'(l); b++) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = mem_word(a + 32'(4*b));
                    bus.mem_rd_last  = (b == int'(l));
                    bus.cache_inv_i  = inv_on_beat && (b == 1);
                    beat_cnt         = b + 1;
                    @(negedge clk);
                    if (rst_n !== 1'b1) break;
                end
                bus.mem_rd_valid = 1'b0;
                bus.mem_rd_last  = 1'b0;
                bus.cache_inv_i  = 1'b0;
            end
        end
    end

    // Monitor: a response is the first non-stalled cycle after an accepted address.
    initial begin : monitor
        bit outstanding;
        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                outstanding = 1'b0;
            end else begin
                if (outstanding && bus.icache_stall === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=%h required=none", bus.inst_rdata);
                    end else begin
                        check("inst_rdata", bus.inst_rdata, exp_q.pop_front());
                    end
                    outstanding = 1'b0;
                end
                if (bus.icache_ask === 1'b1) outstanding = 1'b1;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, output bit first);
        int n;
        n     = 0;
        first = 1'b1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = a;
        #1;
        while (bus.icache_ask !== 1'b1 && n < 300) begin
            first = 1'b0;
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.icache_ask === 1'b1) begin
            exp_q.push_back(d);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_ask required=ask addr=%h", a);
        end
        @(negedge clk);
        bus.inst_sram_en = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=%0d required=0 pending", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stim
        bit f1, f2, f3;
        int c, n;
        rst_n              = 1'b0;
        bus.inst_sram_en   = 1'b0;
        bus.inst_sram_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_ask_idle",  {31'h0, bus.icache_ask},   32'h0);
        check("reset_stall",     {31'h0, bus.icache_stall}, 32'h0);
        check("reset_rdata",     bus.inst_rdata,            32'h0);
        check("reset_mem_req",   {31'h0, bus.mem_rd_req},   32'h0);
        bus.inst_sram_en = 1'b1;
        #1;
        check("reset_ask_en",    {31'h0, bus.icache_ask},   32'h1);
        bus.inst_sram_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Uncached boot ROM fetch, then its kseg0 alias must still miss
        exp_mem_q.push_back({32'h1FC0_0000, 8'd0});
        fetch(32'hBFC0_0000, 32'h3C08_BFC0, f1);
        #1;
        check("uc_stall_high", {31'h0, bus.icache_stall}, 32'h1);
        wait_resp();
        exp_mem_q.push_back({32'h1FC0_0000, 8'd3});
        fetch(32'h9FC0_0000, 32'h3C08_BFC0, f1);
        wait_resp();

        // Cold miss, then a hit in the filled line with no memory traffic
        exp_mem_q.push_back({32'h0000_1000, 8'd3});
        fetch(32'h8000_1004, 32'h0000_0022, f1);
        wait_resp();
        c = n_mem_req;
        fetch(32'h8000_100C, 32'h0000_0044, f1);
        check("hit_first_try", {31'h0, f1}, 32'h1);
        wait_resp();
        check("hit_no_mem_req", n_mem_req, c);

        // Back-to-back hits, one per cycle
        fetch(32'h8000_1000, 32'h0000_0011, f1);
        fetch(32'h8000_1004, 32'h0000_0022, f2);
        fetch(32'h8000_1008, 32'h0000_0033, f3);
        wait_resp();
        check("b2b_ask0", {31'h0, f1}, 32'h1);
        check("b2b_ask1", {31'h0, f2}, 32'h1);
        check("b2b_ask2", {31'h0, f3}, 32'h1);
        check("b2b_no_mem_req", n_mem_req, c);

        // Conflict on index 0
        exp_mem_q.push_back({32'h0000_3000, 8'd3});
        fetch(32'h8000_3000, 32'h0000_00A0, f1);
        wait_resp();
        exp_mem_q.push_back({32'h0000_1000, 8'd3});
        fetch(32'h8000_1000, 32'h0000_0011, f1);
        wait_resp();

        // Long memory stall with fetch-side noise
        ready_delay = 5;
        exp_mem_q.push_back({32'h0000_2000, 8'd3});
        fetch(32'h8000_2008, 32'hC0DE_2008, f1);
        for (int i = 0; i < 5; i++) begin
            bus.inst_sram_en   = (i % 2 == 0);
            bus.inst_sram_addr = 32'h8000_5000 + 32'(4*i);
            #1;
            check("no_accept_in_stall", {31'h0, bus.icache_ask}, 32'h0);
            @(negedge clk);
        end
        bus.inst_sram_en = 1'b0;
        wait_resp();
        ready_delay = 1;

        // Invalidate during refill: the fill still answers, then everything misses
        inv_on_beat = 1'b1;
        exp_mem_q.push_back({32'h0000_1040, 8'd3});
        fetch(32'h8000_1048, 32'hC0DE_1048, f1);
        wait_resp();
        inv_on_beat = 1'b0;
        exp_mem_q.push_back({32'h0000_1040, 8'd3});
        fetch(32'h8000_1048, 32'hC0DE_1048, f1);
        wait_resp();
        exp_mem_q.push_back({32'h0000_2000, 8'd3});
        fetch(32'h8000_2008, 32'hC0DE_2008, f1);
        wait_resp();

        // Reset in the middle of a refill
        c = n_mem_req;
        exp_mem_q.push_back({32'h0000_4000, 8'd3});
        fetch(32'h8000_4000, 32'hC0DE_4000, f1);
        n = 0;
        while (!(n_mem_req > c && beat_cnt >= 2) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("refill_reached", {31'h0, (n_mem_req > c && beat_cnt >= 2)}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_stall_low", {31'h0, bus.icache_stall}, 32'h0);
        check("rst_rdata",     bus.inst_rdata,            32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_mem_q.push_back({32'h0000_4000, 8'd3});
        fetch(32'h8000_4000, 32'hC0DE_4000, f1);
        wait_resp();

        check("exp_q_empty",     exp_q.size(),     32'h0);
        check("exp_mem_q_empty", exp_mem_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
